// File: rtl/guitar_hero_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | guitar_hero_pkg                                                            |
// | Shared grade/state encodings and default judgement zone bounds.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package guitar_hero_pkg;

    typedef enum logic [1:0] {
        GR_NONE    = 2'd0,
        GR_BAD     = 2'd1,
        GR_GOOD    = 2'd2,
        GR_PERFECT = 2'd3
    } grade_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam int c_PERFECT_LO = 370;
    localparam int c_PERFECT_HI = 390;
    localparam int c_GOOD_LO    = 350;
    localparam int c_GOOD_HI    = 410;
    localparam int c_MISS_Y     = 420;

endpackage
`default_nettype wire

// File: rtl/hit_judge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hit_judge_if                                                               |
// | Note-manager inputs and score/display outputs of the hit judge.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface hit_judge_if #(
    parameter int LANES   = 3,
    parameter int Y_W     = 10,
    parameter int SCORE_W = 17
);
    logic                   enable;
    logic [LANES-1:0]       btn_n;
    logic [LANES-1:0]       note_valid;
    logic [LANES*Y_W-1:0]   note_y;
    logic [SCORE_W-1:0]     score;
    logic [7:0]             combo;
    logic [2:0]             mult;
    logic                   hit_pulse;
    logic [2:0]             hit_lane;
    logic [1:0]             hit_grade;
    logic                   miss_pulse;
    logic [LANES-1:0]       note_clear;

    modport master (
        output enable, btn_n, note_valid, note_y,
        input  score, combo, mult, hit_pulse, hit_lane, hit_grade, miss_pulse, note_clear
    );

    modport slave (
        input  enable, btn_n, note_valid, note_y,
        output score, combo, mult, hit_pulse, hit_lane, hit_grade, miss_pulse, note_clear
    );
endinterface
`default_nettype wire

// File: rtl/hit_zone_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hit_zone_classifier                                                        |
// | Combinational note position to grade, half-open zone bounds.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hit_zone_classifier
    import guitar_hero_pkg::*;
#(
    parameter int Y_W        = 10,
    parameter int PERFECT_LO = c_PERFECT_LO,
    parameter int PERFECT_HI = c_PERFECT_HI,
    parameter int GOOD_LO    = c_GOOD_LO,
    parameter int GOOD_HI    = c_GOOD_HI
) (
    input  logic [Y_W-1:0] i_y,
    output grade_e         o_grade
);
    localparam logic [Y_W-1:0] c_P_LO = Y_W'(PERFECT_LO);
    localparam logic [Y_W-1:0] c_P_HI = Y_W'(PERFECT_HI);
    localparam logic [Y_W-1:0] c_G_LO = Y_W'(GOOD_LO);
    localparam logic [Y_W-1:0] c_G_HI = Y_W'(GOOD_HI);

    always_comb begin
        o_grade = GR_BAD;
        if ((i_y >= c_P_LO) && (i_y < c_P_HI)) begin
            o_grade = GR_PERFECT;
        end else if ((i_y >= c_G_LO) && (i_y < c_G_HI)) begin
            o_grade = GR_GOOD;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hit_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hit_judge                                                                  |
// | Grades key presses against lane notes, tracks misses, combo and score.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hit_judge
    import guitar_hero_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int Y_W        = 10,
    parameter int SCORE_W    = 17,
    parameter int PERFECT_LO = c_PERFECT_LO,
    parameter int PERFECT_HI = c_PERFECT_HI,
    parameter int GOOD_LO    = c_GOOD_LO,
    parameter int GOOD_HI    = c_GOOD_HI,
    parameter int MISS_Y     = c_MISS_Y,
    parameter int COOLDOWN   = 500000,
    parameter int COMBO_STEP = 8,
    parameter int MULT_MAX   = 4
) (
    input  logic          clk,
    input  logic          rst,
    hit_judge_if.slave    bus
);
    localparam int                 c_CNT_W     = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(COOLDOWN - 1);
    localparam logic [Y_W-1:0]     c_MISS_THR  = Y_W'(MISS_Y);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;
    localparam logic [7:0]         c_STEP      = 8'(COMBO_STEP);
    localparam logic [8:0]         c_MULT_MAX9 = 9'(MULT_MAX);

    state_e               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [LANES-1:0]     r_btn_prev, r_miss_flag, r_note_clear;
    logic [LANES-1:0]     w_press, w_cand, w_miss_new, w_sel_oh;
    logic [Y_W-1:0]       w_y [LANES];
    logic [Y_W-1:0]       w_sel_y;
    logic [2:0]           w_sel;
    logic                 w_active, w_judge, w_hit_ok;
    grade_e               w_grade;
    logic [1:0]           w_base;
    logic [4:0]           w_add;
    logic [SCORE_W+3:0]   w_sum;
    logic [7:0]           w_combo_q;
    logic [8:0]           w_mult_raw;
    logic [2:0]           w_mult;
    logic [SCORE_W-1:0]   r_score;
    logic [7:0]           r_combo;
    logic                 r_hit_pulse, r_miss_pulse;
    logic [2:0]           r_hit_lane;
    logic [1:0]           r_hit_grade;

    assign w_active = bus.enable && (r_state != ST_IDLE);
    assign w_press  = r_btn_prev & ~bus.btn_n;
    assign w_cand   = w_press & bus.note_valid;
    assign w_judge  = bus.enable && (r_state == ST_ARMED) && (|w_cand);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_y[gi]        = bus.note_y[gi*Y_W +: Y_W];
        assign w_miss_new[gi] = w_active && bus.note_valid[gi] &&
                                (w_y[gi] >= c_MISS_THR) && !r_miss_flag[gi];
    end

    // Descending scan so the lowest-index candidate lane wins.
    always_comb begin
        w_sel   = 3'd0;
        w_sel_y = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel   = 3'(i);
                w_sel_y = w_y[i];
            end
        end
    end

    hit_zone_classifier #(
        .Y_W        (Y_W),
        .PERFECT_LO (PERFECT_LO),
        .PERFECT_HI (PERFECT_HI),
        .GOOD_LO    (GOOD_LO),
        .GOOD_HI    (GOOD_HI)
    ) u_zone (
        .i_y     (w_sel_y),
        .o_grade (w_grade)
    );

    assign w_hit_ok = w_judge && ((w_grade == GR_PERFECT) || (w_grade == GR_GOOD));
    assign w_sel_oh = LANES'(1) << w_sel;
    assign w_base   = (w_grade == GR_PERFECT) ? 2'd2 : ((w_grade == GR_GOOD) ? 2'd1 : 2'd0);

    // Multiplier follows the registered combo, so a hit scores at the pre-hit rate.
    assign w_combo_q  = r_combo / c_STEP;
    assign w_mult_raw = {1'b0, w_combo_q} + 9'd1;
    assign w_mult     = (w_mult_raw > c_MULT_MAX9) ? c_MULT_MAX9[2:0] : w_mult_raw[2:0];
    assign w_add      = {3'b000, w_base} * {2'b00, w_mult};
    assign w_sum      = {4'b0000, r_score} + {{(SCORE_W-1){1'b0}}, w_add};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (w_judge) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_prev   <= '1;
            r_miss_flag  <= '0;
            r_note_clear <= '0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_hit_lane   <= 3'd0;
            r_hit_grade  <= 2'd0;
            r_score      <= '0;
            r_combo      <= 8'd0;
        end else begin
            r_btn_prev   <= bus.btn_n;
            r_miss_flag  <= (r_miss_flag | w_miss_new) & bus.note_valid;
            r_hit_pulse  <= w_judge;
            r_miss_pulse <= |w_miss_new;
            r_note_clear <= w_miss_new | (w_hit_ok ? w_sel_oh : '0);
            if (w_judge) begin
                r_hit_lane  <= w_sel;
                r_hit_grade <= w_grade;
                if (w_hit_ok) begin
                    r_score <= (w_sum > {4'b0000, c_SCORE_MAX}) ? c_SCORE_MAX : w_sum[SCORE_W-1:0];
                end else if (r_score != '0) begin
                    r_score <= r_score - SCORE_W'(1);
                end
            end
            if (|w_miss_new) begin
                r_combo <= 8'd0;
            end else if (w_judge) begin
                r_combo <= !w_hit_ok ? 8'd0 : ((r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1);
            end
        end
    end

    assign bus.score      = r_score;
    assign bus.combo      = r_combo;
    assign bus.mult       = w_mult;
    assign bus.hit_pulse  = r_hit_pulse;
    assign bus.hit_lane   = r_hit_lane;
    assign bus.hit_grade  = r_hit_grade;
    assign bus.miss_pulse = r_miss_pulse;
    assign bus.note_clear = r_note_clear;
endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hit_judge                                                               |
// | Directed scoreboard bench for hit_judge (COOLDOWN shortened to 2).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hit_judge;
    logic clk;
    logic rst;

    hit_judge_if #(.LANES(3), .Y_W(10), .SCORE_W(17)) bus ();

    hit_judge #(
        .LANES    (3),
        .Y_W      (10),
        .SCORE_W  (17),
        .COOLDOWN (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [16:0] score;
        logic [7:0]  combo;
        logic [2:0]  mult;
        logic        hp;
        logic [2:0]  hl;
        logic [1:0]  hg;
        logic        mp;
        logic [2:0]  nc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [16:0] s, input logic [7:0] c, input logic [2:0] m,
                        input logic hp, input logic [2:0] hl, input logic [1:0] hg,
                        input logic mp, input logic [2:0] nc);
        exp_t e;
        e = '{score: s, combo: c, mult: m, hp: hp, hl: hl, hg: hg, mp: mp, nc: nc};
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL %s scoreboard empty got=0 exp=1", tag);
            return;
        end
        e = sb.pop_front();
        total++;
        assert (bus.score === e.score) else begin bad++; $error("FAIL %s score got=%0d exp=%0d", tag, bus.score, e.score); end
        total++;
        assert (bus.combo === e.combo) else begin bad++; $error("FAIL %s combo got=%0d exp=%0d", tag, bus.combo, e.combo); end
        total++;
        assert (bus.mult === e.mult) else begin bad++; $error("FAIL %s mult got=%0d exp=%0d", tag, bus.mult, e.mult); end
        total++;
        assert (bus.hit_pulse === e.hp) else begin bad++; $error("FAIL %s hit_pulse got=%b exp=%b", tag, bus.hit_pulse, e.hp); end
        total++;
        assert (bus.hit_lane === e.hl) else begin bad++; $error("FAIL %s hit_lane got=%0d exp=%0d", tag, bus.hit_lane, e.hl); end
        total++;
        assert (bus.hit_grade === e.hg) else begin bad++; $error("FAIL %s hit_grade got=%0d exp=%0d", tag, bus.hit_grade, e.hg); end
        total++;
        assert (bus.miss_pulse === e.mp) else begin bad++; $error("FAIL %s miss_pulse got=%b exp=%b", tag, bus.miss_pulse, e.mp); end
        total++;
        assert (bus.note_clear === e.nc) else begin bad++; $error("FAIL %s note_clear got=%b exp=%b", tag, bus.note_clear, e.nc); end
    endtask

    // Push the expectation, clock once, then compare just after the edge.
    task automatic step(input string tag, input logic [16:0] s, input logic [7:0] c,
                        input logic [2:0] m, input logic hp, input logic [2:0] hl,
                        input logic [1:0] hg, input logic mp, input logic [2:0] nc);
        push(s, c, m, hp, hl, hg, mp, nc);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] ys(input int y2, input int y1, input int y0);
        return {10'(y2), 10'(y1), 10'(y0)};
    endfunction

    initial begin
        logic [16:0] exp_sc;
        logic [2:0]  exp_m;

        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.btn_n      = 3'b111;
        bus.note_valid = 3'b000;
        bus.note_y     = '0;
        #12;
        push(17'd0, 8'd0, 3'd1, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000);
        check("reset");

        @(posedge clk); #1;
        rst        = 1'b0;
        bus.enable = 1'b1;
        tick();

        // Bad grade at score 0: no underflow, combo stays 0.
        bus.note_valid = 3'b001; bus.note_y = ys(0, 0, 100); bus.btn_n = 3'b110;
        step("bad_y100", 17'd0, 8'd0, 3'd1, 1'b1, 3'd0, 2'd1, 1'b0, 3'b000);
        bus.btn_n = 3'b111; bus.note_valid = 3'b000;
        step("bad_strobe_off", 17'd0, 8'd0, 3'd1, 1'b0, 3'd0, 2'd1, 1'b0, 3'b000);
        tick();

        bus.btn_n = 3'b101;
        step("press_no_note", 17'd0, 8'd0, 3'd1, 1'b0, 3'd0, 2'd1, 1'b0, 3'b000);
        bus.btn_n = 3'b111;
        tick();

        bus.note_valid = 3'b010; bus.note_y = ys(0, 380, 0); bus.btn_n = 3'b101;
        step("perfect_l1", 17'd2, 8'd1, 3'd1, 1'b1, 3'd1, 2'd3, 1'b0, 3'b010);
        bus.btn_n = 3'b111; bus.note_valid = 3'b000;
        step("perfect_strobe_off", 17'd2, 8'd1, 3'd1, 1'b0, 3'd1, 2'd3, 1'b0, 3'b000);
        tick();

        // Good hit, re-press inside the lockout, then a press after it expires.
        bus.note_valid = 3'b001; bus.note_y = ys(0, 0, 360); bus.btn_n = 3'b110;
        step("good_l0", 17'd3, 8'd2, 3'd1, 1'b1, 3'd0, 2'd2, 1'b0, 3'b001);
        bus.btn_n = 3'b111;
        step("good_release", 17'd3, 8'd2, 3'd1, 1'b0, 3'd0, 2'd2, 1'b0, 3'b000);
        bus.btn_n = 3'b110;
        step("lockout_ignore", 17'd3, 8'd2, 3'd1, 1'b0, 3'd0, 2'd2, 1'b0, 3'b000);
        bus.btn_n = 3'b111;
        tick();
        bus.btn_n = 3'b110;
        step("after_cooldown", 17'd4, 8'd3, 3'd1, 1'b1, 3'd0, 2'd2, 1'b0, 3'b001);
        bus.btn_n = 3'b111; bus.note_valid = 3'b000;
        tick();
        tick();

        bus.note_valid = 3'b101; bus.note_y = ys(380, 0, 380); bus.btn_n = 3'b010;
        step("dual_lowest_lane", 17'd6, 8'd4, 3'd1, 1'b1, 3'd0, 2'd3, 1'b0, 3'b001);
        bus.btn_n = 3'b111; bus.note_valid = 3'b000;
        tick();
        tick();

        // Unplayed note on lane 2 ramps through MISS_Y.
        bus.note_valid = 3'b100; bus.note_y = ys(410, 0, 0);
        step("y410", 17'd6, 8'd4, 3'd1, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000);
        bus.note_y = ys(419, 0, 0);
        step("y419", 17'd6, 8'd4, 3'd1, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000);
        bus.note_y = ys(420, 0, 0);
        step("miss_y420", 17'd6, 8'd0, 3'd1, 1'b0, 3'd0, 2'd3, 1'b1, 3'b100);
        bus.note_y = ys(425, 0, 0);
        step("miss_once", 17'd6, 8'd0, 3'd1, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000);
        bus.note_y = ys(430, 0, 0);
        step("miss_hold", 17'd6, 8'd0, 3'd1, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000);
        bus.note_valid = 3'b000;
        step("valid_drop", 17'd6, 8'd0, 3'd1, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000);
        bus.note_valid = 3'b100;
        step("miss_rearm", 17'd6, 8'd0, 3'd1, 1'b0, 3'd0, 2'd3, 1'b1, 3'b100);
        bus.note_valid = 3'b000;
        step("rearm_off", 17'd6, 8'd0, 3'd1, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000);

        // Async reset in the middle of a lockout.
        bus.note_valid = 3'b001; bus.note_y = ys(0, 0, 380); bus.btn_n = 3'b110;
        step("pre_rst_hit", 17'd8, 8'd1, 3'd1, 1'b1, 3'd0, 2'd3, 1'b0, 3'b001);
        #2;
        rst = 1'b1;
        bus.btn_n = 3'b111; bus.note_valid = 3'b000;
        #1;
        push(17'd0, 8'd0, 3'd1, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000);
        check("async_rst");
        #2;
        rst = 1'b0;
        step("post_rst", 17'd0, 8'd0, 3'd1, 1'b0, 3'd0, 2'd0, 1'b0, 3'b000);

        // Nine perfect hits: multiplier steps to 2 once combo reaches 8.
        bus.note_valid = 3'b010; bus.note_y = ys(0, 380, 0);
        for (int k = 1; k <= 9; k++) begin
            exp_sc = (k <= 8) ? 17'(2 * k) : 17'(16 + 4 * (k - 8));
            exp_m  = (k >= 8) ? 3'd2 : 3'd1;
            bus.btn_n = 3'b101;
            step($sformatf("combo_hit%0d", k), exp_sc, 8'(k), exp_m, 1'b1, 3'd1, 2'd3, 1'b0, 3'b010);
            bus.btn_n = 3'b111;
            tick();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/hit_judge.md
# hit_judge

Parametrised hit-judgement and scoring engine for the rhythm-game datapath. Sits between the note manager (per-lane note positions) and the display/score outputs. Grades button presses against per-lane note positions and detects missed notes. Maintains a combo counter, a score multiplier and a saturating score, and tells the note manager which note to retire. Supports LANES columns, with configurable zone bounds and lockout period.

## Interface
- LANES, 3, number of note columns (1..8)
- Y_W, 10, note position width
- SCORE_W, 17, score width
- PERFECT_LO / PERFECT_HI, 370 / 390, perfect zone, half-open [LO,HI)
- GOOD_LO / GOOD_HI, 350 / 410, good zone, half-open; must contain perfect zone
- MISS_Y, 420, note_y at or beyond this counts as missed
- COOLDOWN, 500000, lockout cycles after a judged press (≥1)
- COMBO_STEP, 8, combo hits per multiplier step
- MULT_MAX, 4, multiplier ceiling
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  game active; low freezes judging, counters hold
- btn_n  in  LANES  active-low keys, already synchronised to clk
- note_valid  in  LANES  lane holds a live note
- note_y  in  LANES*Y_W  packed note positions, lane i at [i*Y_W +: Y_W]
- score  out  SCORE_W  accumulated score
- combo  out  8  consecutive-hit count, saturates at 255
- mult  out  3  current multiplier
- hit_pulse  out  1  one-cycle strobe: press judged
- hit_lane  out  3  lane of last judgement
- hit_grade  out  2  0 none, 1 bad, 2 good, 3 perfect
- miss_pulse  out  1  one-cycle strobe: note passed MISS_Y unplayed
- note_clear  out  LANES  one-cycle strobe per lane; retire that note

## Operation
- Reset values: score 0, combo 0, mult 1, hit_lane 0, hit_grade 0, all strobes 0, btn history all 1 (released), miss flags 0, state IDLE.
- Press detect: press[i] = prev_btn_n[i] & ~btn_n[i]. prev_btn_n updates every cycle, including while IDLE or in LOCKOUT.
- States:
  - IDLE: entered while enable=0; goes to ARMED when enable=1.
  - ARMED: judges presses.
  - LOCKOUT: counter loads COOLDOWN-1 and counts down; returns to ARMED after the cycle it reads 0. Presses are ignored.
  - Any state goes to IDLE when enable=0; the lockout counter clears.
- Simultaneous presses: only the lowest-index pressed lane with note_valid=1 is judged. The others are dropped. A press on a lane with note_valid=0 is ignored and has no score effect.
- Grading on y = note_y[lane]:
  - perfect if PERFECT_LO≤y<PERFECT_HI; base 2.
  - else good if GOOD_LO≤y<GOOD_HI; base 1.
  - else bad.
- Perfect or good: score += base*mult, saturating at 2^SCORE_W−1. Combo +1. note_clear[lane] asserted.
- Bad: score −1, saturating at 0. Combo reset to 0. No note_clear.
- Every judged press (any grade) asserts hit_pulse and enters LOCKOUT.
- mult = min(1 + combo/COMBO_STEP, MULT_MAX). It is recomputed from the registered combo, so the new combo affects the next hit, not the current one.
- Miss: per-lane flag fires when note_valid[i]=1, y≥MISS_Y and the flag is clear. This pulses miss_pulse and note_clear[i], resets combo and leaves score unchanged. The flag clears when note_valid[i] falls.
- Misses are detected in ARMED and LOCKOUT, not in IDLE. If several lanes miss in the same cycle, there is one miss_pulse; all of those note_clear bits assert.
- Miss and hit in the same cycle: the hit updates score, and combo resets to 0 (miss wins for combo).

## Timing
- Press edge on cycle E: all outputs update at the clk edge ending E, visible in E+1. Latency is 1 cycle.
- Strobes are high for exactly one cycle.
- LOCKOUT blocks presses for exactly COOLDOWN cycles after the judging cycle.
- Async rst mid-LOCKOUT returns to IDLE with reset values. If enable is high when rst releases, ARMED is entered on the first clock after release.

## Structure
- Shared package guitar_hero_pkg: grade enum (GR_NONE/BAD/GOOD/PERFECT), state enum, default zone constants.
- Sub-module hit_zone_classifier: combinational y to grade, parametrised by zone bounds. One instance on the muxed selected lane; the miss compare is per lane in the top.

## Test plan
- Lane 1, y=380, press, combo 0: grade 3, score 0→2, note_clear=3'b010, hit_pulse 1 cycle.
- Press at y=360, then release and press again within COOLDOWN: first judged good (score +1), second ignored. A press after COOLDOWN cycles is judged.
- Lanes 0 and 2 pressed together, both valid at y=380: only lane 0 judged, hit_lane=0.
- 8 perfect hits (COOLDOWN=2 bench): score 16, combo 8, mult 2; 9th perfect adds 4 (score 20).
- Press at y=100 with score 0: grade 1, score stays 0, combo 0.
- Note y ramps 410→430 unplayed: miss_pulse once at y=420, combo cleared. No second pulse until note_valid drops and rises again.
